// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and sizes for the iterative 32-bit multiply/divide unit.
// Contents: operation encoding, controller state encoding, datapath widths,
// iteration count and a magnitude helper.
package muldiv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned DLEN   = 2 * XLEN;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned ITER_C = 32;

  // Operation select: bit 1 selects divide, bit 0 selects signed.
  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_MUL  = 2'b01,
    OP_DIVU = 2'b10,
    OP_DIV  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Absolute value when treated as signed; 0x80000000 maps to itself (unsigned 2^31).
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? XLEN'(~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the shared multiply/divide datapath.
// Ports:
//   acc_i  - 64-bit accumulator before the step
//   opnd_i - multiplicand magnitude (multiply) or divisor magnitude (divide)
//   div_i  - 1 selects a restoring-divide step, 0 a shift-add multiply step
//   acc_o  - accumulator after the step
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic [DLEN-1:0] acc_i,
  input  logic [XLEN-1:0] opnd_i,
  input  logic            div_i,
  output logic [DLEN-1:0] acc_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem;
  logic [XLEN+1:0] diff;

  always_comb begin
    // Multiply: accumulator is {partial product high, remaining multiplier bits}.
    sum  = {1'b0, acc_i[DLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : (XLEN+1)'(0));
    // Divide: accumulator is {partial remainder, remaining dividend / quotient bits}.
    // The shifted remainder can reach 33 bits, so the trial subtract is 34 bits wide.
    rem  = {acc_i[DLEN-1:XLEN], acc_i[XLEN-1]};
    diff = {1'b0, rem} - {2'b00, opnd_i};
    if (div_i) begin
      if (diff[XLEN+1]) begin
        acc_o = {rem[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end else begin
        acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv32.sv
// muldiv32: iterative 32x32 multiply (64-bit result) and 32/32 divide, one bit per cycle.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid / in_ready   - request handshake; A, B, Op sampled on acceptance
//   A, B, Op              - operands and operation (MULU, MUL, DIVU, DIV)
//   out_valid / out_ready - result handshake
//   Hi, Lo                - product {Hi,Lo}, or remainder / quotient
//   DivZero               - result came from a divide by zero
//   Busy                  - an operation is running or its result is pending
module muldiv32
  import muldiv_pkg::*;
#(
  parameter int unsigned ITER = ITER_C
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [1:0]      Op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Hi,
  output logic [XLEN-1:0] Lo,
  output logic            DivZero,
  output logic            Busy
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DLEN-1:0]  acc_q;
  logic [XLEN-1:0]  opnd_q;
  logic             is_div_q;
  logic             neg_lo_q;
  logic             neg_hi_q;
  logic [XLEN-1:0]  hi_q;
  logic [XLEN-1:0]  lo_q;
  logic             dz_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  op_e              op_in;
  logic             in_div;
  logic             in_signed;
  logic [XLEN-1:0]  a_mag;
  logic [XLEN-1:0]  b_mag;
  logic [DLEN-1:0]  acc_d;
  logic [DLEN-1:0]  prod;
  logic [XLEN-1:0]  hi_d;
  logic [XLEN-1:0]  lo_d;

  // Decode the incoming request and form operand magnitudes.
  always_comb begin
    op_in     = op_e'(Op);
    in_div    = (op_in == OP_DIVU) || (op_in == OP_DIV);
    in_signed = (op_in == OP_MUL)  || (op_in == OP_DIV);
    a_mag     = mag(A, in_signed);
    b_mag     = mag(B, in_signed);
  end

  muldiv_step u_step (
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .div_i  (is_div_q),
    .acc_o  (acc_d)
  );

  // Sign fix-up applied to the final step's output as it is written to Hi/Lo.
  always_comb begin
    prod = neg_lo_q ? DLEN'(~acc_d + DLEN'(1)) : acc_d;
    hi_d = prod[DLEN-1:XLEN];
    lo_d = prod[XLEN-1:0];
    if (is_div_q) begin
      lo_d = neg_lo_q ? XLEN'(~acc_d[XLEN-1:0] + XLEN'(1)) : acc_d[XLEN-1:0];
      hi_d = neg_hi_q ? XLEN'(~acc_d[DLEN-1:XLEN] + XLEN'(1)) : acc_d[DLEN-1:XLEN];
    end
  end

  // Controller and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      is_div_q    <= 1'b0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            is_div_q   <= in_div;
            neg_lo_q   <= in_signed && (A[XLEN-1] ^ B[XLEN-1]);
            neg_hi_q   <= in_signed && in_div && A[XLEN-1];
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (in_div && (B == '0)) begin
              // Divide by zero bypasses the iteration entirely.
              state_q     <= S_DONE;
              hi_q        <= A;
              lo_q        <= '1;
              dz_q        <= 1'b1;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= S_RUN;
              acc_q   <= in_div ? {XLEN'(0), a_mag} : {XLEN'(0), b_mag};
              opnd_q  <= in_div ? b_mag : a_mag;
            end
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER - 1)) begin
            state_q     <= S_DONE;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            dz_q        <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign DivZero   = dz_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_muldiv32.sv
// tb_muldiv32: directed and randomized checks of muldiv32 against an arithmetic reference.
module tb_muldiv32;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [1:0]  Op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        DivZero;
  logic        Busy;

  int n_checks;
  int n_fail;

  muldiv32 #(.ITER(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Op        (Op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Hi        (Hi),
    .Lo        (Lo),
    .DivZero   (DivZero),
    .Busy      (Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result {DivZero, Hi, Lo} from plain integer arithmetic.
  function automatic logic [64:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint          q;
    longint          r;
    logic [63:0]     p;
    logic [31:0]     hi;
    logic [31:0]     lo;
    logic            dz;
    sa = $signed(a);
    sb = $signed(b);
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin
        p  = {32'h0, a} * {32'h0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      2'b01: begin
        p  = 64'(sa * sb);
        hi = p[63:32];
        lo = p[31:0];
      end
      default: begin
        if (b == 32'h0) begin
          dz = 1'b1;
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else if (op == 2'b10) begin
          lo = a / b;
          hi = a % b;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          lo = 32'(q);
          hi = 32'(r);
        end
      end
    endcase
    return {dz, hi, lo};
  endfunction

  // Issue one request, scramble inputs while it runs, hold the result for `hold` cycles, then take it.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string tag);
    logic [64:0] exp;
    int          lat;
    int          n;
    int          exp_lat;
    exp     = ref_model(op, a, b);
    exp_lat = (op[1] && (b == 32'h0)) ? 1 : 33;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, " in_ready before accept"}, 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    A        = a;
    B        = b;
    Op       = op;
    @(negedge clk);
    lat = 1;
    check_eq({tag, " busy after accept"}, 64'(Busy), 64'(1));
    check_eq({tag, " in_ready low after accept"}, 64'(in_ready), 64'(0));
    while (!out_valid && lat < 40) begin
      in_valid = 1'($urandom);
      A        = $urandom;
      B        = $urandom;
      Op       = 2'($urandom);
      @(negedge clk);
      lat++;
    end
    check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
    for (int h = 0; h < hold; h++) begin
      check_eq({tag, " held out_valid"}, 64'(out_valid), 64'(1));
      check_eq({tag, " held in_ready"}, 64'(in_ready), 64'(0));
      check_eq({tag, " held result"}, {31'h0, DivZero, Hi, Lo}, 64'(exp));
      in_valid = 1'($urandom);
      A        = $urandom;
      B        = $urandom;
      @(negedge clk);
    end
    check_eq({tag, " Hi"}, 64'(Hi), 64'(exp[63:32]));
    check_eq({tag, " Lo"}, 64'(Lo), 64'(exp[31:0]));
    check_eq({tag, " DivZero"}, 64'(DivZero), 64'(exp[64]));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check_eq({tag, " in_ready after take"}, 64'(in_ready), 64'(1));
    check_eq({tag, " out_valid after take"}, 64'(out_valid), 64'(0));
    check_eq({tag, " busy after take"}, 64'(Busy), 64'(0));
    check_eq({tag, " idle keeps result"}, {Hi, Lo}, exp[63:0]);
  endtask

  logic [31:0] corner [5];

  initial begin
    int n_ov;
    logic [31:0] ra;
    logic [31:0] rb;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    A         = '0;
    B         = '0;
    Op        = '0;
    corner[0] = 32'h0000_0000;
    corner[1] = 32'h0000_0001;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000;
    corner[4] = 32'h7FFF_FFFF;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("reset in_ready", 64'(in_ready), 64'(1));
    check_eq("reset out_valid", 64'(out_valid), 64'(0));
    check_eq("reset busy", 64'(Busy), 64'(0));
    check_eq("reset result", {31'h0, DivZero, Hi, Lo}, 64'(0));

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulu max");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "mul -1*-1");
    run_op(2'b10, 32'd100, 32'd7, 0, "divu 100/7");
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 2, "div -7/2");
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div overflow");
    run_op(2'b10, 32'd5, 32'd0, 0, "divu by zero");
    run_op(2'b11, 32'hFFFF_FFF0, 32'd0, 1, "div by zero");
    run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 10, "backpressure");

    // Reset during RUN must abort with no result.
    in_valid = 1'b1;
    Op       = 2'b00;
    A        = 32'hDEAD_BEEF;
    B        = 32'h0BAD_F00D;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort in_ready", 64'(in_ready), 64'(1));
    check_eq("abort out_valid", 64'(out_valid), 64'(0));
    check_eq("abort busy", 64'(Busy), 64'(0));
    check_eq("abort cleared result", {31'h0, DivZero, Hi, Lo}, 64'(0));
    n_ov = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) n_ov++;
    end
    check_eq("abort no out_valid", 64'(n_ov), 64'(0));
    run_op(2'b00, 32'd3, 32'd4, 0, "mulu 3x4");

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'h0;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 255));
      run_op(2'($urandom), ra, rb, $urandom_range(0, 3), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
